// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - IMEM read port and decode handoff bundle for fetch_ctrl
interface fetch_ctrl_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic              imem_rvalid;
    logic [DATA_W-1:0] imem_rdata;
    logic              dec_valid;
    logic [DATA_W-1:0] dec_instr;
    logic [ADDR_W-1:0] dec_pc;
    logic              dec_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rvalid,
        input  imem_rdata,
        output dec_valid,
        output dec_instr,
        output dec_pc,
        input  dec_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rvalid,
        output imem_rdata,
        input  dec_valid,
        input  dec_instr,
        input  dec_pc,
        output dec_ready
    );
endinterface

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-fetch sequencer: PC, single-outstanding IMEM read, decode buffer
module fetch_ctrl #(
    parameter int                ADDR_W   = 10,
    parameter int                OFF_W    = 20,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_base,
    input  logic [OFF_W-1:0]  redirect_offset,
    fetch_ctrl_if.master      bus,
    output logic [ADDR_W-1:0] pc_out,
    output logic              misalign_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;
    state_t            resume;
    logic [ADDR_W-1:0] pc_q;
    logic              drop_q;
    logic              drop_d;
    logic              mis_q;
    logic [DATA_W-1:0] instr_q;
    logic [ADDR_W-1:0] dpc_q;

    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] target_aligned;
    logic              rv_done;
    logic              accept;
    logic              stale_in_flight;
    logic              unused_offset_hi;

    // Sums wrap mod 2^ADDR_W, so only the low ADDR_W offset bits affect the target.
    assign target           = redirect_base + redirect_offset[ADDR_W-1:0];
    assign target_aligned   = {target[ADDR_W-1:2], 2'b00};
    assign unused_offset_hi = ^redirect_offset[OFF_W-1:ADDR_W];

    assign rv_done = (state_q == S_WAIT) && bus.imem_rvalid;
    assign accept  = rv_done && !drop_q;

    // A redirect leaves a read in flight only if it was accepted this cycle or has not
    // returned yet; data returning in the redirect cycle itself is simply discarded.
    assign stale_in_flight = ((state_q == S_REQ) && bus.imem_ack) ||
                             ((state_q == S_WAIT) && !bus.imem_rvalid);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        resume  = enable ? S_REQ : S_IDLE;
        state_d = state_q;
        drop_d  = drop_q;
        case (state_q)
            S_IDLE: if (enable) state_d = S_REQ;
            S_REQ:  if (bus.imem_ack) state_d = S_WAIT;
            S_WAIT: if (bus.imem_rvalid) state_d = drop_q ? resume : S_HOLD;
            S_HOLD: if (bus.dec_ready) state_d = resume;
            default: state_d = S_IDLE;
        endcase
        if (rv_done) begin
            drop_d = 1'b0;
        end
        if (redirect) begin
            if (stale_in_flight) begin
                state_d = S_WAIT;
                drop_d  = 1'b1;
            end else begin
                state_d = resume;
            end
        end
    end

    always_comb begin
        bus.imem_req  = (state_q == S_REQ);
        bus.imem_addr = pc_q;
        bus.dec_valid = (state_q == S_HOLD);
        bus.dec_instr = instr_q;
        bus.dec_pc    = dpc_q;
        pc_out        = pc_q;
        misalign_err  = mis_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            drop_q  <= 1'b0;
            mis_q   <= 1'b0;
            instr_q <= '0;
            dpc_q   <= '0;
        end else begin
            drop_q <= drop_d;
            mis_q  <= redirect && (target[1:0] != 2'b00);
            if (redirect) begin
                pc_q <= target_aligned;
            end else if (accept) begin
                pc_q <= pc_q + ADDR_W'(4);
            end
            if (accept && !redirect) begin
                instr_q <= bus.imem_rdata;
                dpc_q   <= pc_q;
            end
        end
    end

endmodule
